// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared codes for the multi-cycle controller: ALU ops, opcodes,
//               FSM states, select encodings and the decoded instruction class.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

    localparam logic [3:0] c_alu_add = 4'd0;
    localparam logic [3:0] c_alu_sub = 4'd1;
    localparam logic [3:0] c_alu_or  = 4'd2;
    localparam logic [3:0] c_alu_slt = 4'd3;
    localparam logic [3:0] c_alu_lui = 4'd4;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_lui   = 6'h0F;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    localparam logic [5:0] c_fn_jr   = 6'h08;
    localparam logic [5:0] c_fn_addu = 6'h21;
    localparam logic [5:0] c_fn_subu = 6'h23;
    localparam logic [5:0] c_fn_slt  = 6'h2A;

    localparam logic [1:0] c_npc_pc4 = 2'd0;
    localparam logic [1:0] c_npc_br  = 2'd1;
    localparam logic [1:0] c_npc_jal = 2'd2;
    localparam logic [1:0] c_npc_jr  = 2'd3;

    localparam logic [1:0] c_wd_alu = 2'd0;
    localparam logic [1:0] c_wd_dm  = 2'd1;
    localparam logic [1:0] c_wd_pc4 = 2'd2;

    localparam logic [1:0] c_dst_rt = 2'd0;
    localparam logic [1:0] c_dst_rd = 2'd1;
    localparam logic [1:0] c_dst_ra = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    // One-hot instruction class; exactly one field is set by the decoder.
    typedef struct packed {
        logic addu;
        logic subu;
        logic slt;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic jal;
        logic jr;
        logic nop;
    } instr_cls_t;

    function automatic logic is_rtype(input instr_cls_t c);
        return c.addu | c.subu | c.slt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_decode.sv
// ============================================================================
// Module      : mc_decode
// Description : Combinational opcode/funct to one-hot instruction class.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output instr_cls_t o_cls
);

    always_comb begin
        o_cls = '0;
        case (i_opcode)
            c_op_rtype: begin
                case (i_funct)
                    c_fn_addu: o_cls.addu = 1'b1;
                    c_fn_subu: o_cls.subu = 1'b1;
                    c_fn_slt:  o_cls.slt  = 1'b1;
                    c_fn_jr:   o_cls.jr   = 1'b1;
                    default:   o_cls.nop  = 1'b1;
                endcase
            end
            c_op_ori: o_cls.ori = 1'b1;
            c_op_lw:  o_cls.lw  = 1'b1;
            c_op_sw:  o_cls.sw  = 1'b1;
            c_op_beq: o_cls.beq = 1'b1;
            c_op_lui: o_cls.lui = 1'b1;
            c_op_jal: o_cls.jal = 1'b1;
            default:  o_cls.nop = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
// ============================================================================
// Module      : mc_ctrl
// Description : Multi-cycle control FSM sequencing FETCH/DECODE/EXEC/MEM/WB.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               cmp_eq,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         npc_sel,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               alu_src_b,
    output logic               ext_op,
    output logic               dm_we,
    output logic               reg_we,
    output logic [1:0]         reg_dst,
    output logic [1:0]         wd_sel,
    output logic [2:0]         state_o
);

    state_t     r_state;
    state_t     w_state_nxt;
    instr_cls_t w_cls_live;
    instr_cls_t r_cls;
    logic       r_boot;

    logic [3:0] w_alu_op;
    logic [3:0] w_exe_alu_op;
    logic       w_exe_src_b;
    logic       w_exe_ext;

    mc_decode u_decode (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_cls    (w_cls_live)
    );

    // r_boot keeps every strobe quiet for the cycle right after reset drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_cls   <= '{nop: 1'b1, default: 1'b0};
            r_boot  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_boot  <= 1'b0;
            if (r_state == ST_DECODE) begin
                r_cls <= w_cls_live;
            end
        end
    end

    // ALU-side controls of the latched instruction, held from EXEC through WB.
    always_comb begin
        w_exe_alu_op = c_alu_add;
        if (r_cls.subu || r_cls.beq) w_exe_alu_op = c_alu_sub;
        else if (r_cls.slt)          w_exe_alu_op = c_alu_slt;
        else if (r_cls.ori)          w_exe_alu_op = c_alu_or;
        else if (r_cls.lui)          w_exe_alu_op = c_alu_lui;
        w_exe_src_b = r_cls.ori | r_cls.lw | r_cls.sw | r_cls.lui;
        w_exe_ext   = r_cls.lw | r_cls.sw;
    end

    always_comb begin
        w_state_nxt = r_state;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        npc_sel     = c_npc_pc4;
        w_alu_op    = c_alu_add;
        alu_src_b   = 1'b0;
        ext_op      = 1'b0;
        dm_we       = 1'b0;
        reg_we      = 1'b0;
        reg_dst     = c_dst_rt;
        wd_sel      = c_wd_alu;

        if (reset || r_boot) begin
            w_state_nxt = ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    ir_we       = 1'b1;
                    pc_we       = 1'b1;
                    npc_sel     = c_npc_pc4;
                    w_state_nxt = ST_DECODE;
                end
                ST_DECODE: begin
                    if (w_cls_live.jal) begin
                        pc_we       = 1'b1;
                        npc_sel     = c_npc_jal;
                        reg_we      = 1'b1;
                        reg_dst     = c_dst_ra;
                        wd_sel      = c_wd_pc4;
                        w_state_nxt = ST_FETCH;
                    end else if (w_cls_live.jr) begin
                        pc_we       = 1'b1;
                        npc_sel     = c_npc_jr;
                        w_state_nxt = ST_FETCH;
                    end else if (w_cls_live.nop) begin
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    w_alu_op  = w_exe_alu_op;
                    alu_src_b = w_exe_src_b;
                    ext_op    = w_exe_ext;
                    if (r_cls.beq) begin
                        pc_we       = cmp_eq;
                        npc_sel     = c_npc_br;
                        w_state_nxt = ST_FETCH;
                    end else if (r_cls.lw || r_cls.sw) begin
                        w_state_nxt = ST_MEM;
                    end else if (r_cls.jal || r_cls.jr || r_cls.nop) begin
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_WB;
                    end
                end
                ST_MEM: begin
                    w_alu_op  = w_exe_alu_op;
                    alu_src_b = w_exe_src_b;
                    ext_op    = w_exe_ext;
                    if (r_cls.lw) begin
                        w_state_nxt = ST_WB;
                    end else begin
                        dm_we       = r_cls.sw;
                        w_state_nxt = ST_FETCH;
                    end
                end
                ST_WB: begin
                    w_alu_op    = w_exe_alu_op;
                    alu_src_b   = w_exe_src_b;
                    ext_op      = w_exe_ext;
                    reg_we      = 1'b1;
                    reg_dst     = is_rtype(r_cls) ? c_dst_rd : c_dst_rt;
                    wd_sel      = r_cls.lw ? c_wd_dm : c_wd_alu;
                    w_state_nxt = ST_FETCH;
                end
                default: begin
                    w_state_nxt = ST_FETCH;
                end
            endcase
        end
    end

    assign alu_op  = ALUOP_W'(w_alu_op);
    assign state_o = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// ============================================================================
// Module      : tb_mc_ctrl
// Description : Directed scoreboard bench for mc_ctrl; expected per-cycle
//               outputs are queued as stimulus is applied, then compared.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] npc;
        logic [3:0] alu;
        logic       src_b;
        logic       ext;
        logic       dm_we;
        logic       reg_we;
        logic [1:0] dst;
        logic [1:0] wd;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  v;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       cmp_eq;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] npc_sel;
    logic [3:0] alu_op;
    logic       alu_src_b;
    logic       ext_op;
    logic       dm_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic [2:0] state_o;

    exp_t sb[$];
    int   n_chk;
    int   n_err;

    mc_ctrl #(.ALUOP_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .cmp_eq    (cmp_eq),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .npc_sel   (npc_sel),
        .alu_op    (alu_op),
        .alu_src_b (alu_src_b),
        .ext_op    (ext_op),
        .dm_we     (dm_we),
        .reg_we    (reg_we),
        .reg_dst   (reg_dst),
        .wd_sel    (wd_sel),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_chk, n_err);
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t mk(input logic [2:0] st, input logic ir, input logic pc,
                                input logic [1:0] npc, input logic [3:0] alu,
                                input logic srcb, input logic ext, input logic dm,
                                input logic rw, input logic [1:0] dst, input logic [1:0] wd);
        obs_t o;
        o = '{st, ir, pc, npc, alu, srcb, ext, dm, rw, dst, wd};
        return o;
    endfunction

    // Push the expectation for the current cycle, then check it mid-cycle.
    task automatic cyc(input string tag, input obs_t e);
        exp_t x;
        obs_t got;
        sb.push_back('{tag, e});
        @(negedge clk);
        got = {state_o, ir_we, pc_we, npc_sel, alu_op, alu_src_b, ext_op,
               dm_we, reg_we, reg_dst, wd_sel};
        x = sb.pop_front();
        n_chk++;
        assert (got === x.v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", x.tag, got, x.v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string nm, input logic [5:0] op, input logic [5:0] fn,
                                input obs_t dec);
        opcode = op;
        funct  = fn;
        cyc({nm, "_fetch"}, mk(3'd0, 1, 1, 2'd0, 4'd0, 0, 0, 0, 0, 2'd0, 2'd0));
        cyc({nm, "_decode"}, dec);
    endtask

    obs_t dec_quiet;

    initial begin
        n_chk  = 0;
        n_err  = 0;
        reset  = 1'b1;
        opcode = 6'h00;
        funct  = 6'h00;
        cmp_eq = 1'b0;
        dec_quiet = mk(3'd1, 0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 2'd0, 2'd0);

        @(posedge clk);
        #1;
        cyc("reset_hold", mk(3'd0, 0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 2'd0, 2'd0));
        reset = 1'b0;
        cyc("post_reset", mk(3'd0, 0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 2'd0, 2'd0));

        // addu; IR changes after DECODE must not disturb the sequence
        fetch_decode("addu", 6'h00, 6'h21, dec_quiet);
        opcode = 6'h23;
        funct  = 6'h00;
        cyc("addu_exec", mk(3'd2, 0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 2'd0, 2'd0));
        cyc("addu_wb",   mk(3'd4, 0, 0, 2'd0, 4'd0, 0, 0, 0, 1, 2'd1, 2'd0));

        fetch_decode("lw", 6'h23, 6'h00, dec_quiet);
        cyc("lw_exec", mk(3'd2, 0, 0, 2'd0, 4'd0, 1, 1, 0, 0, 2'd0, 2'd0));
        cyc("lw_mem",  mk(3'd3, 0, 0, 2'd0, 4'd0, 1, 1, 0, 0, 2'd0, 2'd0));
        cyc("lw_wb",   mk(3'd4, 0, 0, 2'd0, 4'd0, 1, 1, 0, 1, 2'd0, 2'd1));

        cmp_eq = 1'b1;
        fetch_decode("beq_t", 6'h04, 6'h00, dec_quiet);
        cyc("beq_t_exec", mk(3'd2, 0, 1, 2'd1, 4'd1, 0, 0, 0, 0, 2'd0, 2'd0));
        cmp_eq = 1'b0;
        fetch_decode("beq_n", 6'h04, 6'h00, dec_quiet);
        cyc("beq_n_exec", mk(3'd2, 0, 0, 2'd1, 4'd1, 0, 0, 0, 0, 2'd0, 2'd0));

        fetch_decode("jal", 6'h03, 6'h00, mk(3'd1, 0, 1, 2'd2, 4'd0, 0, 0, 0, 1, 2'd2, 2'd2));
        fetch_decode("jr",  6'h00, 6'h08, mk(3'd1, 0, 1, 2'd3, 4'd0, 0, 0, 0, 0, 2'd0, 2'd0));
        fetch_decode("unk", 6'h3F, 6'h00, dec_quiet);

        fetch_decode("ori", 6'h0D, 6'h00, dec_quiet);
        cyc("ori_exec", mk(3'd2, 0, 0, 2'd0, 4'd2, 1, 0, 0, 0, 2'd0, 2'd0));
        cyc("ori_wb",   mk(3'd4, 0, 0, 2'd0, 4'd2, 1, 0, 0, 1, 2'd0, 2'd0));

        fetch_decode("lui", 6'h0F, 6'h00, dec_quiet);
        cyc("lui_exec", mk(3'd2, 0, 0, 2'd0, 4'd4, 1, 0, 0, 0, 2'd0, 2'd0));
        cyc("lui_wb",   mk(3'd4, 0, 0, 2'd0, 4'd4, 1, 0, 0, 1, 2'd0, 2'd0));

        fetch_decode("subu", 6'h00, 6'h23, dec_quiet);
        cyc("subu_exec", mk(3'd2, 0, 0, 2'd0, 4'd1, 0, 0, 0, 0, 2'd0, 2'd0));
        cyc("subu_wb",   mk(3'd4, 0, 0, 2'd0, 4'd1, 0, 0, 0, 1, 2'd1, 2'd0));

        fetch_decode("slt", 6'h00, 6'h2A, dec_quiet);
        cyc("slt_exec", mk(3'd2, 0, 0, 2'd0, 4'd3, 0, 0, 0, 0, 2'd0, 2'd0));
        cyc("slt_wb",   mk(3'd4, 0, 0, 2'd0, 4'd3, 0, 0, 0, 1, 2'd1, 2'd0));

        fetch_decode("sw", 6'h2B, 6'h00, dec_quiet);
        cyc("sw_exec", mk(3'd2, 0, 0, 2'd0, 4'd0, 1, 1, 0, 0, 2'd0, 2'd0));
        cyc("sw_mem",  mk(3'd3, 0, 0, 2'd0, 4'd0, 1, 1, 1, 0, 2'd0, 2'd0));

        // sw aborted by reset in its MEM cycle
        fetch_decode("sw_abort", 6'h2B, 6'h00, dec_quiet);
        cyc("sw_abort_exec", mk(3'd2, 0, 0, 2'd0, 4'd0, 1, 1, 0, 0, 2'd0, 2'd0));
        reset = 1'b1;
        cyc("sw_abort_mem", mk(3'd3, 0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 2'd0, 2'd0));
        reset = 1'b0;
        cyc("sw_abort_quiet", mk(3'd0, 0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 2'd0, 2'd0));
        fetch_decode("after_abort", 6'h3F, 6'h00, dec_quiet);
        cyc("after_abort_next", mk(3'd0, 1, 1, 2'd0, 4'd0, 0, 0, 0, 0, 2'd0, 2'd0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
